// File: rtl/sccb_pkg.sv
// Shared SCCB target definitions: FSM state encoding, default device
// address and the bus levels that mean ACK / NACK in the ninth bit.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV,
        S_ACK_DEV,
        S_AH,
        S_ACK_AH,
        S_AL,
        S_ACK_AL,
        S_WD,
        S_ACK_WD,
        S_RD,
        S_MACK,
        S_WAIT
    } state_t;

    localparam logic [6:0] OV5647_ADDR = 7'h36;
    localparam logic       SDA_ACK     = 1'b0;
    localparam logic       SDA_NACK    = 1'b1;

endpackage

// File: rtl/sccb_bus_sync.sv
// SCL/SDA synchronizers and bus event detector; events are registered so
// they appear 3 clk after the pin edge, with sda aligned to them.
module sccb_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_s;
    logic [1:0] sda_s;
    logic       scl_h;
    logic       sda_h;

    // Resets to the idle-bus level so leaving reset never fakes a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s    <= 2'b11;
            sda_s    <= 2'b11;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
            sda      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_s    <= {scl_s[0], scl_i};
            sda_s    <= {sda_s[0], sda_i};
            scl_h    <= scl_s[1];
            sda_h    <= sda_s[1];
            sda      <= sda_s[1];
            scl_rise <= scl_s[1] & ~scl_h;
            scl_fall <= ~scl_s[1] & scl_h;
            start    <= scl_s[1] & scl_h & sda_h & ~sda_s[1];
            stop     <= scl_s[1] & scl_h & ~sda_h & sda_s[1];
        end
    end

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target with 16-bit register addressing and an internal byte
// register file; ACKs and read data are driven through sda_pull.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = OV5647_ADDR,
    parameter int         REG_AW   = 6,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_pull,
    output logic        wr_stb,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam int DEPTH = 1 << REG_AW;

    logic sda, scl_rise, scl_fall, start, stop;

    sccb_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  sh, sh_n;
    logic [15:0] ptr, ptr_n;
    logic        rw, rw_n;
    logic        ack_on, ack_on_n;
    logic        pull_n, wr_stb_n;
    logic [15:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic        mem_we;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  byte_in;
    logic        ptr_ok;
    logic [7:0]  rd_cur;

    assign byte_in = {sh[6:0], sda};
    assign ptr_ok  = (ptr >> REG_AW) == 16'd0;
    assign rd_cur  = ptr_ok ? mem[ptr[REG_AW-1:0]] : 8'h00;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            sh       <= 8'h00;
            ptr      <= 16'h0000;
            rw       <= 1'b0;
            ack_on   <= 1'b0;
            sda_pull <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= 16'h0000;
            wr_data  <= 8'h00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            ptr      <= ptr_n;
            rw       <= rw_n;
            ack_on   <= ack_on_n;
            sda_pull <= pull_n;
            wr_stb   <= wr_stb_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
        end else if (mem_we) begin
            mem[ptr[REG_AW-1:0]] <= byte_in;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        ptr_n     = ptr;
        rw_n      = rw;
        ack_on_n  = ack_on;
        pull_n    = sda_pull;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        mem_we    = 1'b0;
        if (stop) begin
            state_n = S_IDLE;
            pull_n  = 1'b0;
        end else if (start) begin
            state_n = S_DEV;
            cnt_n   = 4'd0;
        end else begin
            case (state)
                S_DEV, S_AH, S_AL, S_WD: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n    = 4'd0;
                            ack_on_n = 1'b0;
                            if (state == S_DEV) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    rw_n    = byte_in[0];
                                    state_n = S_ACK_DEV;
                                end else begin
                                    state_n = S_WAIT;
                                end
                            end else if (state == S_AH) begin
                                ptr_n[15:8] = byte_in;
                                state_n     = S_ACK_AH;
                            end else if (state == S_AL) begin
                                ptr_n[7:0] = byte_in;
                                state_n    = S_ACK_AL;
                            end else begin
                                // Out-of-range writes are ACKed and reported but not stored.
                                wr_stb_n  = 1'b1;
                                wr_addr_n = ptr;
                                wr_data_n = byte_in;
                                mem_we    = ptr_ok;
                                ptr_n     = ptr + 16'd1;
                                state_n   = S_ACK_WD;
                            end
                        end
                    end
                end
                S_ACK_DEV, S_ACK_AH, S_ACK_AL, S_ACK_WD: begin
                    // First fall after the 8th bit pulls SDA; the next one ends the ACK slot.
                    if (scl_fall) begin
                        if (!ack_on) begin
                            pull_n   = 1'b1;
                            ack_on_n = 1'b1;
                        end else begin
                            pull_n = 1'b0;
                            if (state == S_ACK_DEV) begin
                                if (rw) begin
                                    pull_n  = ~rd_cur[7];
                                    sh_n    = {rd_cur[6:0], 1'b0};
                                    cnt_n   = 4'd1;
                                    state_n = S_RD;
                                end else begin
                                    state_n = S_AH;
                                end
                            end else if (state == S_ACK_AH) begin
                                state_n = S_AL;
                            end else begin
                                state_n = S_WD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            // ptr advances once the byte is out, so a NACKed read leaves it on the next byte.
                            pull_n  = 1'b0;
                            ptr_n   = ptr + 16'd1;
                            state_n = S_MACK;
                        end else begin
                            pull_n = ~sh[7];
                            sh_n   = {sh[6:0], 1'b0};
                            cnt_n  = cnt + 4'd1;
                        end
                    end
                end
                S_MACK: begin
                    if (scl_rise) begin
                        if (sda == SDA_ACK) begin
                            sh_n    = rd_cur;
                            cnt_n   = 4'd0;
                            state_n = S_RD;
                        end else begin
                            state_n = S_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bus-level bench for sccb_target: a bit-banged SCCB initiator with an
// open-drain SDA model, table-driven write/readback vectors and corner cases.
module tb_sccb_target;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_i;
    logic        sda_m;
    logic        sda_i;
    logic        sda_pull;
    logic        wr_stb;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    assign sda_i = sda_m & ~sda_pull;

    always #5 clk = ~clk;

    sccb_target dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_pull (sda_pull),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [23:0] stb_q[$];

    always @(negedge clk) if (wr_stb) stb_q.push_back({wr_addr, wr_data});

    typedef struct {
        logic [6:0]  dev;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        acked;
        logic [7:0]  rd;
    } vec_t;

    vec_t vec[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qw();
        scl_i = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_i = 1'b0; qw();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qw();
        scl_i = 1'b1; qw();
        sda_m = 1'b1; qw();
        qw();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; qw();
        scl_i = 1'b1; qw(); qw();
        scl_i = 1'b0; qw();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; qw();
        scl_i = 1'b1; qw();
        b = sda_i; qw();
        scl_i = 1'b0; qw();
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(mack);
    endtask

    task automatic set_ptr(input logic [15:0] a);
        logic ack;
        bus_start();
        put_byte(8'h6C, ack);   chk("ptr_dev_ack", ack, 0);
        put_byte(a[15:8], ack); chk("ptr_ah_ack", ack, 0);
        put_byte(a[7:0], ack);  chk("ptr_al_ack", ack, 0);
    endtask

    task automatic read_at(input logic [15:0] a, output logic [7:0] v);
        logic ack;
        set_ptr(a);
        bus_stop();
        bus_start();
        put_byte(8'h6D, ack); chk("rd_dev_ack", ack, 0);
        get_byte(v, 1'b1);
        bus_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] v;
        int         n0;

        vec[0] = '{7'h36, 16'h0100, 8'h01, 1'b1, 8'h00};
        vec[1] = '{7'h36, 16'h0005, 8'hC3, 1'b1, 8'hC3};
        vec[2] = '{7'h36, 16'h003F, 8'h7E, 1'b1, 8'h7E};
        vec[3] = '{7'h36, 16'h3000, 8'h99, 1'b1, 8'h00};
        vec[4] = '{7'h3C, 16'h0005, 8'h11, 1'b0, 8'hC3};
        vec[5] = '{7'h36, 16'h0040, 8'h55, 1'b1, 8'h00};

        rst = 1'b1; scl_i = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_sda_pull", sda_pull, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        qw();

        foreach (vec[i]) begin
            n0 = stb_q.size();
            bus_start();
            put_byte({vec[i].dev, 1'b0}, ack);
            chk("vec_dev_ack", ack, vec[i].acked ? 0 : 1);
            if (vec[i].acked) begin
                put_byte(vec[i].addr[15:8], ack); chk("vec_ah_ack", ack, 0);
                put_byte(vec[i].addr[7:0], ack);  chk("vec_al_ack", ack, 0);
                put_byte(vec[i].data, ack);       chk("vec_wd_ack", ack, 0);
            end
            bus_stop();
            chk("vec_stb_count", stb_q.size() - n0, vec[i].acked ? 1 : 0);
            if (vec[i].acked) chk("vec_stb_addr_data", stb_q[$], {vec[i].addr, vec[i].data});
            read_at(vec[i].addr, v);
            chk("vec_readback", v, vec[i].rd);
        end
        read_at(16'h0000, v);
        chk("reg0_unchanged", v, 8'h00);

        // Burst write then burst read with ACK, ACK, NACK
        n0 = stb_q.size();
        set_ptr(16'h0010);
        put_byte(8'hA5, ack); chk("burst_ack0", ack, 0);
        put_byte(8'h5A, ack); chk("burst_ack1", ack, 0);
        put_byte(8'h3C, ack); chk("burst_ack2", ack, 0);
        bus_stop();
        chk("burst_stb_count", stb_q.size() - n0, 3);
        if (stb_q.size() - n0 == 3) begin
            chk("burst_stb0", stb_q[n0],     {16'h0010, 8'hA5});
            chk("burst_stb1", stb_q[n0 + 1], {16'h0011, 8'h5A});
            chk("burst_stb2", stb_q[n0 + 2], {16'h0012, 8'h3C});
        end
        set_ptr(16'h0010);
        bus_stop();
        bus_start();
        put_byte(8'h6D, ack); chk("burst_rd_dev_ack", ack, 0);
        get_byte(v, 1'b0); chk("burst_rd0", v, 8'hA5);
        get_byte(v, 1'b0); chk("burst_rd1", v, 8'h5A);
        get_byte(v, 1'b1); chk("burst_rd2", v, 8'h3C);
        chk("burst_released", sda_pull, 0);
        bus_stop();

        // Foreign address: no ACK, busy until STOP, no strobe
        n0 = stb_q.size();
        bus_start();
        put_byte(8'h78, ack); chk("foreign_nack", ack, 1);
        chk("foreign_busy", busy, 1);
        put_byte(8'h12, ack); chk("foreign_nack2", ack, 1);
        bus_stop();
        qw();
        chk("foreign_idle", busy, 0);
        chk("foreign_no_stb", stb_q.size() - n0, 0);

        // Two-phase read, then current-address read shows ptr moved to 0x0011
        read_at(16'h0010, v);
        chk("twophase_rd", v, 8'hA5);
        bus_start();
        put_byte(8'h6D, ack); chk("cur_rd_dev_ack", ack, 0);
        get_byte(v, 1'b1);
        bus_stop();
        chk("cur_rd_ptr_next", v, 8'h5A);

        // Reset during the device-address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(v[i] & 1'b0 | (8'h6C >> i) & 1'b1);
        chk("ackdev_pull", sda_pull, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_release", sda_pull, 0);
        scl_i = 1'b1; sda_m = 1'b1;
        qw();
        rst = 1'b0;
        qw();
        chk("post_rst_idle", busy, 0);
        n0 = stb_q.size();
        set_ptr(16'h0001);
        put_byte(8'h42, ack); chk("post_rst_wd_ack", ack, 0);
        bus_stop();
        chk("post_rst_stb_count", stb_q.size() - n0, 1);
        if (stb_q.size() - n0 == 1) chk("post_rst_stb", stb_q[$], {16'h0001, 8'h42});
        read_at(16'h0001, v);
        chk("post_rst_readback", v, 8'h42);
        read_at(16'h0005, v);
        chk("post_rst_cleared", v, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
